npc_sched: RTL and testbench
============================

// Module: npc_sched
// PURPOSE
//  Job scheduler downstream of the NPU host slave: consumes per-core start pulses with job offset/size,
//  fetches each job's operand region via a DMA read command port in 4KB-safe bursts, then hands the
//  job to its compute core and reports busy/finish back to the slave (which raises irq from slv_fin).
//  One job active at a time; pending jobs served round-robin across cores.
// PARAMETERS
//  NCORE  4    number of cores (slv_stt/slv_fin/slv_bsy/core_* width)
//  MAXB   256  max beats per DMA burst (1..256; cmd_len = beats-1)
// PORTS
//  s_axi_aclk   in   1   clock, all logic rising-edge
//  s_axi_arstn  in   1   reset, synchronous, active-low
//  slv_ofs      in   32  job byte offset, sampled on slv_stt
//  slv_siz      in   32  job byte size, sampled on slv_stt
//  slv_stt      in   NCORE  start pulse per core (1 cycle)
//  slv_fin      out  NCORE  job finish pulse per core (1 cycle)
//  slv_bsy      out  NCORE  core has pending or active job
//  cmd_vld      out  1   DMA read command valid
//  cmd_rdy      in   1   DMA read command ready
//  cmd_adr      out  32  burst start byte address (4B aligned)
//  cmd_len      out  8   burst beats-1 (32-bit beats)
//  cmd_cid      out  2   core id of burst
//  cmd_done     in   1   pulse: previously accepted burst fully completed
//  core_go      out  NCORE  1-cycle kick to core after its data is fetched
//  core_done    in   NCORE  core completion pulse
// BEHAVIOUR
//  Reset (arstn=0 at edge): all outputs 0, all pend/lat regs 0, state IDLE, rr pointer 0.
//  Start: slv_stt[i] & ~slv_bsy[i] -> pend[i]<=1, ofs_i<={slv_ofs[31:2],2'b0}, siz_i<=slv_siz; bsy[i]=1 next cycle.
//   slv_stt[i] while bsy[i] -> ignored (no relatch). Multiple stt bits same cycle -> all latched (same ofs/siz).
//  Beats: beats = ceil(siz/4) = (siz+3)>>2 computed in 33 bits; siz=0 -> no DMA, go straight to GO.
//  FSM: IDLE -> (any pend) grant lowest-index pending at/after rr ptr, cur<=grant, pend[cur]<=0,
//   adr<=ofs_cur, rem<=beats, rr<=cur+1 mod NCORE; next ISSUE (or GO if rem==0).
//   ISSUE: cmd_vld=1, cmd_adr=adr, cmd_cid=cur, cmd_len=n-1 with n=min(rem, MAXB, (4096-adr[11:0])>>2);
//    stable while cmd_vld&~cmd_rdy. On cmd_vld&cmd_rdy: adr<=adr+4n (mod 2^32), rem<=rem-n, -> WAIT.
//   WAIT: one burst outstanding; cmd_done -> ISSUE if rem!=0 else GO. cmd_done outside WAIT ignored.
//   GO: core_go[cur]=1 for exactly one cycle -> RUN.
//   RUN: core_done[cur] -> FIN; core_done for other cores ignored.
//   FIN: slv_fin[cur]=1 one cycle, bsy[cur] cleared same edge -> IDLE.
//  slv_bsy[i] = pend[i] | (state!=IDLE & cur==i). Registered outputs except slv_bsy (from regs).
//  Latency: stt@N -> bsy@N+1, grant@N+1 edge, cmd_vld@N+2 (idle system).
//  4KB rule: no burst crosses a 4096B boundary; address wrap past 2^32 allowed, no error.
//  Reset mid-job: everything aborts to reset values; no fin issued; DMA side must also be reset.
// TESTING
//  siz=1024, ofs=0x1000, stt[0] -> one cmd adr=0x1000 len=255; cmd_done -> core_go[0]; core_done[0] -> slv_fin[0] 1 cycle, bsy[0]=0.
//  siz=40, ofs=0x1FF0 -> cmd adr=0x1FF0 len=3, then adr=0x2000 len=5 (4KB split).
//  siz=0, stt[2] -> no cmd_vld; core_go[2] 2 cycles after grant; fin after core_done[2].
//  siz=6, ofs=0x103 -> cmd adr=0x100 len=1 (aligned down, ceil beats).
//  stt[1] then stt[3],stt[0] while core1 active -> served order 1,3,0 (rr); stt[1] repeated while bsy[1] ignored.
//  cmd_rdy held low 5 cycles -> cmd_vld/adr/len stable; arstn=0 in WAIT -> all outputs 0 next edge, no fin.

Source files
------------

// File: rtl/npc_sched.sv
// NPU job scheduler: latches per-core job requests, fetches each job's operands through a
// DMA read command port in 4KB-safe bursts, kicks the core and reports finish to the slave.
module npc_sched #(
  parameter int NCORE = 4,
  parameter int MAXB  = 256
) (
  input  logic             s_axi_aclk,
  input  logic             s_axi_arstn,
  input  logic [31:0]      slv_ofs,
  input  logic [31:0]      slv_siz,
  input  logic [NCORE-1:0] slv_stt,
  output logic [NCORE-1:0] slv_fin,
  output logic [NCORE-1:0] slv_bsy,
  output logic             cmd_vld,
  input  logic             cmd_rdy,
  output logic [31:0]      cmd_adr,
  output logic [7:0]       cmd_len,
  output logic [1:0]       cmd_cid,
  input  logic             cmd_done,
  output logic [NCORE-1:0] core_go,
  input  logic [NCORE-1:0] core_done
);

  localparam int CW = (NCORE > 1) ? $clog2(NCORE) : 1;
  localparam logic [31:0] MAXB_W = 32'(MAXB);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_GO    = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  // Largest burst from adr that fits the remaining beats, MAXB and the current 4KB page.
  function automatic logic [31:0] burst_beats(input logic [31:0] adr, input logic [31:0] rem);
    logic [31:0] room;
    logic [31:0] n;
    room = (32'd4096 - {20'd0, adr[11:0]}) >> 2;
    n    = (rem < MAXB_W) ? rem : MAXB_W;
    n    = (n < room) ? n : room;
    return n;
  endfunction

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cur_q, cur_d;
  logic [CW-1:0]    rr_q, rr_d;
  logic [CW-1:0]    grant_s;
  logic             grant_vld_s;
  logic [NCORE-1:0] pend_q, pend_d;
  logic [NCORE-1:0] start_s;
  logic [NCORE-1:0] bsy_s;
  logic [NCORE-1:0] go_q, go_d;
  logic [NCORE-1:0] fin_q, fin_d;
  logic [31:0]      ofs_q [NCORE];
  logic [31:0]      ofs_d [NCORE];
  logic [31:0]      siz_q [NCORE];
  logic [31:0]      siz_d [NCORE];
  logic [31:0]      adr_q, adr_d;
  logic [31:0]      rem_q, rem_d;
  logic [32:0]      siz_rnd_s;
  logic [31:0]      beats_s;
  logic [31:0]      n_s;
  logic             cmd_vld_q, cmd_vld_d;
  logic [7:0]       len_q, len_d;

  // Busy is pending-or-active, derived straight from registers.
  always_comb begin
    for (int i = 0; i < NCORE; i++) begin
      bsy_s[i] = pend_q[i] | ((state_q != S_IDLE) && (int'(cur_q) == i));
    end
  end

  assign start_s = slv_stt & ~bsy_s;

  // Round-robin pick: descending scan so the nearest pending core at/after rr_q wins.
  always_comb begin
    grant_s     = '0;
    grant_vld_s = 1'b0;
    for (int k = NCORE - 1; k >= 0; k--) begin
      if (pend_q[(int'(rr_q) + k) % NCORE]) begin
        grant_s     = CW'((int'(rr_q) + k) % NCORE);
        grant_vld_s = 1'b1;
      end else begin
        grant_s     = grant_s;
      end
    end
  end

  assign siz_rnd_s = {1'b0, siz_q[grant_s]} + 33'd3;
  assign beats_s   = {1'b0, siz_rnd_s[32:2]};
  assign n_s       = burst_beats(adr_q, rem_q);

  // Next-state logic for job latching and the fetch/run sequencer.
  always_comb begin
    logic [31:0] n_nxt;
    logic [31:0] len_full;
    state_d = state_q;
    cur_d   = cur_q;
    rr_d    = rr_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    for (int i = 0; i < NCORE; i++) begin
      pend_d[i] = pend_q[i] | start_s[i];
      ofs_d[i]  = start_s[i] ? {slv_ofs[31:2], 2'b00} : ofs_q[i];
      siz_d[i]  = start_s[i] ? slv_siz : siz_q[i];
    end
    case (state_q)
      S_IDLE: begin
        if (grant_vld_s) begin
          cur_d           = grant_s;
          pend_d[grant_s] = 1'b0;
          adr_d           = ofs_q[grant_s];
          rem_d           = beats_s;
          rr_d            = (int'(grant_s) == NCORE - 1) ? '0 : grant_s + 1'b1;
          state_d         = (beats_s == 32'd0) ? S_GO : S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (cmd_rdy) begin
          adr_d   = adr_q + {n_s[29:0], 2'b00};
          rem_d   = rem_q - n_s;
          state_d = S_WAIT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (cmd_done) begin
          state_d = (rem_q != 32'd0) ? S_ISSUE : S_GO;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_GO: state_d = S_RUN;
      S_RUN: begin
        if (core_done[cur_q]) begin
          state_d = S_FIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Command fields are precomputed so they are flop outputs while in ISSUE.
    n_nxt     = burst_beats(adr_d, rem_d);
    len_full  = n_nxt - 32'd1;
    cmd_vld_d = (state_d == S_ISSUE);
    len_d     = (state_d == S_ISSUE) ? len_full[7:0] : 8'd0;
    for (int i = 0; i < NCORE; i++) begin
      go_d[i]  = (state_q == S_GO) && (int'(cur_q) == i);
      fin_d[i] = (state_q == S_FIN) && (int'(cur_q) == i);
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_arstn) begin
      state_q   <= S_IDLE;
      cur_q     <= '0;
      rr_q      <= '0;
      pend_q    <= '0;
      adr_q     <= 32'd0;
      rem_q     <= 32'd0;
      cmd_vld_q <= 1'b0;
      len_q     <= 8'd0;
      go_q      <= '0;
      fin_q     <= '0;
      for (int i = 0; i < NCORE; i++) begin
        ofs_q[i] <= 32'd0;
        siz_q[i] <= 32'd0;
      end
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      rr_q      <= rr_d;
      pend_q    <= pend_d;
      adr_q     <= adr_d;
      rem_q     <= rem_d;
      cmd_vld_q <= cmd_vld_d;
      len_q     <= len_d;
      go_q      <= go_d;
      fin_q     <= fin_d;
      for (int i = 0; i < NCORE; i++) begin
        ofs_q[i] <= ofs_d[i];
        siz_q[i] <= siz_d[i];
      end
    end
  end

  assign slv_bsy = bsy_s;
  assign slv_fin = fin_q;
  assign core_go = go_q;
  assign cmd_vld = cmd_vld_q;
  assign cmd_adr = adr_q;
  assign cmd_len = len_q;
  assign cmd_cid = 2'(cur_q);

endmodule

// File: tb/tb_npc_sched.sv
// Randomized self-checking bench for npc_sched; expected bursts and service order come from
// a plain-arithmetic model of the job/burst rules.
module tb_npc_sched;

  logic        clk = 1'b0;
  logic        arstn;
  logic [31:0] slv_ofs, slv_siz;
  logic [3:0]  slv_stt, slv_fin, slv_bsy, core_go, core_done;
  logic        cmd_vld, cmd_rdy, cmd_done;
  logic [31:0] cmd_adr;
  logic [7:0]  cmd_len;
  logic [1:0]  cmd_cid;

  int checks   = 0;
  int failures = 0;
  int rdy_hold = -1;

  always #5 clk = ~clk;

  npc_sched #(.NCORE(4), .MAXB(256)) dut (
    .s_axi_aclk(clk), .s_axi_arstn(arstn),
    .slv_ofs(slv_ofs), .slv_siz(slv_siz), .slv_stt(slv_stt),
    .slv_fin(slv_fin), .slv_bsy(slv_bsy),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_adr(cmd_adr),
    .cmd_len(cmd_len), .cmd_cid(cmd_cid), .cmd_done(cmd_done),
    .core_go(core_go), .core_done(core_done)
  );

  // Serve the job of one core: DMA responder, core responder, checks against the burst model.
  task automatic serve(input int core, input logic [31:0] ofs, input logic [31:0] siz,
                       input string nm, output int go_w);
    logic [31:0] a;
    longint      b;
    int          n, room, w, hold;
    bit          bad;
    a    = {ofs[31:2], 2'b00};
    b    = (longint'(siz) + 3) / 4;
    go_w = 0;
    while (b > 0) begin
      room = (4096 - int'(a[11:0])) / 4;
      n    = (b < 256) ? int'(b) : 256;
      if (n > room) n = room;
      w = 0;
      while (cmd_vld !== 1'b1 && w < 40) begin @(negedge clk); w++; end
      checks++;
      if (cmd_vld !== 1'b1) begin
        failures++;
        $display("FAIL %s cmd_vld_timeout got=%b want=1", nm, cmd_vld);
        return;
      end
      checks++;
      if (cmd_adr !== a || cmd_len !== 8'(n - 1) || cmd_cid !== 2'(core) || core_go !== 4'd0) begin
        failures++;
        $display("FAIL %s cmd got adr=%h len=%0d cid=%0d go=%b want adr=%h len=%0d cid=%0d go=0000",
                 nm, cmd_adr, cmd_len, cmd_cid, core_go, a, n - 1, core);
      end
      hold = (rdy_hold >= 0) ? rdy_hold : int'($urandom_range(0, 3));
      bad  = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        if (cmd_vld !== 1'b1 || cmd_adr !== a || cmd_len !== 8'(n - 1)) bad = 1'b1;
      end
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL %s cmd_stable got vld=%b adr=%h len=%0d want vld=1 adr=%h len=%0d",
                 nm, cmd_vld, cmd_adr, cmd_len, a, n - 1);
      end
      cmd_rdy = 1'b1;
      @(negedge clk);
      cmd_rdy = 1'b0;
      checks++;
      if (cmd_vld !== 1'b0) begin
        failures++;
        $display("FAIL %s vld_drop got=%b want=0", nm, cmd_vld);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      cmd_done = 1'b1;
      @(negedge clk);
      cmd_done = 1'b0;
      a = a + 32'(4 * n);
      b = b - n;
    end
    bad = 1'b0;
    while (core_go === 4'd0 && go_w < 40) begin
      if (cmd_vld !== 1'b0) bad = 1'b1;
      @(negedge clk);
      go_w++;
    end
    checks++;
    if (core_go !== 4'(1 << core) || bad) begin
      failures++;
      $display("FAIL %s core_go got=%b want=%b extra_cmd=%b", nm, core_go, 4'(1 << core), bad);
    end
    @(negedge clk);
    checks++;
    if (core_go !== 4'd0) begin
      failures++;
      $display("FAIL %s go_pulse got=%b want=0000", nm, core_go);
    end
    core_done = 4'(1 << ((core + 1) % 4));
    @(negedge clk);
    core_done = 4'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (slv_fin !== 4'd0 || slv_bsy[core] !== 1'b1) begin
      failures++;
      $display("FAIL %s other_done got fin=%b bsy=%b want fin=0000 bsy[%0d]=1", nm, slv_fin, slv_bsy, core);
    end
    core_done = 4'(1 << core);
    @(negedge clk);
    core_done = 4'd0;
    w = 0;
    while (slv_fin === 4'd0 && w < 20) begin @(negedge clk); w++; end
    checks++;
    if (slv_fin !== 4'(1 << core) || slv_bsy[core] !== 1'b0) begin
      failures++;
      $display("FAIL %s fin got fin=%b bsy=%b want fin=%b bsy[%0d]=0", nm, slv_fin, slv_bsy, 4'(1 << core), core);
    end
    @(negedge clk);
    checks++;
    if (slv_fin !== 4'd0) begin
      failures++;
      $display("FAIL %s fin_pulse got=%b want=0000", nm, slv_fin);
    end
  endtask

  task automatic run_job(input int core, input logic [31:0] ofs, input logic [31:0] siz, input string nm);
    int gw;
    slv_stt = 4'(1 << core);
    slv_ofs = ofs;
    slv_siz = siz;
    @(negedge clk);
    slv_stt = 4'd0;
    checks++;
    if (slv_bsy[core] !== 1'b1) begin
      failures++;
      $display("FAIL %s bsy_set got=%b want bit %0d set", nm, slv_bsy, core);
    end
    serve(core, ofs, siz, nm, gw);
  endtask

  task automatic do_reset();
    arstn = 1'b0;
    repeat (3) @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({slv_fin, slv_bsy, core_go, cmd_vld, cmd_adr, cmd_len, cmd_cid} !== 55'd0) begin
      failures++;
      $display("FAIL reset outputs got fin=%b bsy=%b go=%b vld=%b adr=%h len=%0d cid=%0d want all 0",
               slv_fin, slv_bsy, core_go, cmd_vld, cmd_adr, cmd_len, cmd_cid);
    end
  endtask

  task automatic test_latency();
    int gw;
    slv_stt = 4'b0001; slv_ofs = 32'h40; slv_siz = 32'd16;
    @(negedge clk);
    slv_stt = 4'd0;
    checks++;
    if (slv_bsy !== 4'b0001 || cmd_vld !== 1'b0) begin
      failures++;
      $display("FAIL latency_n1 got bsy=%b vld=%b want bsy=0001 vld=0", slv_bsy, cmd_vld);
    end
    @(negedge clk);
    checks++;
    if (cmd_vld !== 1'b1) begin
      failures++;
      $display("FAIL latency_n2 got vld=%b want 1", cmd_vld);
    end
    serve(0, 32'h40, 32'd16, "latency", gw);
  endtask

  task automatic test_directed();
    rdy_hold = 5;
    run_job(0, 32'h1000, 32'd1024, "single_1k");
    rdy_hold = -1;
    run_job(1, 32'h1FF0, 32'd40, "split_4k");
    run_job(3, 32'h103, 32'd6, "unaligned");
    run_job(2, 32'hFFFF_FFF0, 32'd64, "wrap");
    run_job(1, 32'h800, 32'd2048, "maxb_page");
  endtask

  task automatic test_zero_size();
    int gw;
    slv_stt = 4'b0100; slv_ofs = 32'h300; slv_siz = 32'd0;
    @(negedge clk);
    slv_stt = 4'd0;
    @(negedge clk);
    serve(2, 32'h300, 32'd0, "zero_size", gw);
    checks++;
    if (gw !== 1) begin
      failures++;
      $display("FAIL zero_go_latency got=%0d want=1 extra cycles", gw);
    end
  endtask

  task automatic test_rr();
    logic [31:0] ofs_m [4];
    logic [31:0] siz_m [4];
    logic [3:0]  pend;
    int          order [3];
    int          ptr, gw;
    ofs_m[1] = 32'h0;    siz_m[1] = 32'd8;
    ofs_m[3] = 32'($urandom_range(0, 32'hFFFF)); siz_m[3] = 32'($urandom_range(1, 600));
    ofs_m[0] = 32'($urandom_range(0, 32'hFFFF)); siz_m[0] = 32'($urandom_range(0, 600));
    slv_stt = 4'b0010; slv_ofs = ofs_m[1]; slv_siz = siz_m[1];
    @(negedge clk);
    slv_stt = 4'd0;
    @(negedge clk);
    slv_stt = 4'b1000; slv_ofs = ofs_m[3]; slv_siz = siz_m[3];
    @(negedge clk);
    slv_stt = 4'b0001; slv_ofs = ofs_m[0]; slv_siz = siz_m[0];
    @(negedge clk);
    slv_stt = 4'b0010; slv_ofs = 32'h7000; slv_siz = 32'd4;
    @(negedge clk);
    slv_stt = 4'd0;
    checks++;
    if (slv_bsy !== 4'b1011) begin
      failures++;
      $display("FAIL rr_bsy got=%b want=1011", slv_bsy);
    end
    order[0] = 1;
    pend = 4'b1001;
    ptr = 2;
    for (int j = 1; j < 3; j++) begin
      for (int k = 3; k >= 0; k--) if (pend[(ptr + k) % 4]) order[j] = (ptr + k) % 4;
      pend[order[j]] = 1'b0;
      ptr = (order[j] + 1) % 4;
    end
    for (int j = 0; j < 3; j++) serve(order[j], ofs_m[order[j]], siz_m[order[j]], $sformatf("rr_job%0d", j), gw);
    repeat (4) @(negedge clk);
    checks++;
    if (slv_bsy !== 4'd0 || cmd_vld !== 1'b0) begin
      failures++;
      $display("FAIL rr_ignored_restart got bsy=%b vld=%b want bsy=0000 vld=0", slv_bsy, cmd_vld);
    end
  endtask

  task automatic test_random();
    logic [31:0] base, ofs, siz;
    int          core;
    for (int i = 0; i < 10; i++) begin
      core = int'($urandom_range(0, 3));
      base = $urandom();
      if ($urandom_range(0, 1) == 1) ofs = base;
      else ofs = {base[31:12], 12'h000} - 32'($urandom_range(0, 80));
      siz = 32'($urandom_range(0, 2500));
      run_job(core, ofs, siz, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_reset_mid();
    int w;
    bit bad;
    slv_stt = 4'b0010; slv_ofs = 32'h200; slv_siz = 32'd64;
    @(negedge clk);
    slv_stt = 4'd0;
    w = 0;
    while (cmd_vld !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    cmd_rdy = 1'b1;
    @(negedge clk);
    cmd_rdy = 1'b0;
    @(negedge clk);
    arstn = 1'b0;
    @(negedge clk);
    checks++;
    if ({slv_fin, slv_bsy, core_go, cmd_vld, cmd_adr, cmd_len, cmd_cid} !== 55'd0) begin
      failures++;
      $display("FAIL mid_reset got fin=%b bsy=%b go=%b vld=%b adr=%h len=%0d want all 0",
               slv_fin, slv_bsy, core_go, cmd_vld, cmd_adr, cmd_len);
    end
    arstn = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (slv_fin !== 4'd0 || cmd_vld !== 1'b0 || slv_bsy !== 4'd0 || core_go !== 4'd0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL mid_reset_quiet got fin=%b vld=%b bsy=%b want all idle", slv_fin, cmd_vld, slv_bsy);
    end
  endtask

  initial begin
    arstn = 1'b0; slv_ofs = 32'd0; slv_siz = 32'd0; slv_stt = 4'd0;
    cmd_rdy = 1'b0; cmd_done = 1'b0; core_done = 4'd0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_directed();
    test_zero_size();
    test_rr();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

endmodule
